// File: rtl/pwm_multich_if.sv
// Control/status bundle between register logic and the multi-channel PWM.
// Latency: none (plain wires grouped for port hygiene).
// Backpressure: none; load_i is a fire-and-forget pulse acknowledged by loadAck_o.
interface pwm_multich_if #(
  parameter int PWM_BW   = 8,
  parameter int CHANNELS = 4
) ();
  logic                         en_i;
  logic                         mode_i;
  logic [PWM_BW-1:0]            periodCnt_i;
  logic [CHANNELS*PWM_BW-1:0]   onCnt_i;
  logic [CHANNELS-1:0]          polarity_i;
  logic                         load_i;
  logic                         loadAck_o;
  logic                         cycleStart_o;
  logic [PWM_BW-1:0]            count_o;
  logic [CHANNELS-1:0]          pwm_o;

  // Register/control side
  modport master (
    output en_i, mode_i, periodCnt_i, onCnt_i, polarity_i, load_i,
    input  loadAck_o, cycleStart_o, count_o, pwm_o
  );

  // PWM block side
  modport slave (
    input  en_i, mode_i, periodCnt_i, onCnt_i, polarity_i, load_i,
    output loadAck_o, cycleStart_o, count_o, pwm_o
  );
endinterface

// File: rtl/pwm_multich.sv
// Multi-channel PWM: shared up / up-down counter, per-channel compare, double-buffered settings.
// Latency: pwm_o lags count_o by 1 cycle; shadow loads take effect at the next period boundary.
// Backpressure: none; a load before the apply overwrites the pending set (last write wins).
module pwm_multich #(
  parameter int PWM_BW   = 8,
  parameter int CHANNELS = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  pwm_multich_if.slave   bus
);

  localparam logic [PWM_BW-1:0] CNT_ZERO = '0;
  localparam logic [PWM_BW-1:0] CNT_ONE  = {{(PWM_BW-1){1'b0}}, 1'b1};

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Counter and run state
  logic [PWM_BW-1:0]          count_q, count_d;
  dir_e                       dir_q, dir_d;
  logic                       run_q, run_d;

  // Active settings (drive the counter and compares)
  logic                       mode_q, mode_d;
  logic [PWM_BW-1:0]          per_q, per_d;
  logic [CHANNELS*PWM_BW-1:0] on_q, on_d;
  logic [CHANNELS-1:0]        pol_q, pol_d;

  // Pending settings (captured by load_i, waiting for a boundary)
  logic                       pmode_q, pmode_d;
  logic [PWM_BW-1:0]          pper_q, pper_d;
  logic [CHANNELS*PWM_BW-1:0] pon_q, pon_d;
  logic [CHANNELS-1:0]        ppol_q, ppol_d;
  logic                       pend_q, pend_d;

  // Registered outputs
  logic                       ack_q, ack_d;
  logic                       cstart_q, cstart_d;
  logic [CHANNELS-1:0]        pwm_q, pwm_d;
  logic [CHANNELS-1:0]        raw;

  // An edge is an apply edge whenever the next cycle has count 0: either a
  // period wrap while running, the first edge of a run, or any idle edge.
  logic                       apply;
  assign apply = (count_d == CNT_ZERO);

  // Counter next state: edge mode wraps P->0, center mode bounces P -> 1 -> 0.
  always_comb begin
    count_d = CNT_ZERO;
    dir_d   = DIR_UP;
    run_d   = bus.en_i;
    if (bus.en_i && run_q) begin
      if (per_q == CNT_ZERO) begin
        count_d = CNT_ZERO;
      end else if (!mode_q) begin
        count_d = (count_q >= per_q) ? CNT_ZERO : count_q + CNT_ONE;
      end else if (dir_q == DIR_UP) begin
        if (count_q >= per_q) begin
          count_d = per_q - CNT_ONE;
          dir_d   = DIR_DOWN;
        end else begin
          count_d = count_q + CNT_ONE;
          dir_d   = DIR_UP;
        end
      end else begin
        count_d = count_q - CNT_ONE;
        dir_d   = DIR_DOWN;
      end
      // Reaching 0 always starts a new period counting up.
      if (count_d == CNT_ZERO) begin
        dir_d = DIR_UP;
      end
    end
  end

  // Shadow handling: loads go to pending, or straight to active on an apply edge.
  always_comb begin
    mode_d  = mode_q;
    per_d   = per_q;
    on_d    = on_q;
    pol_d   = pol_q;
    pmode_d = pmode_q;
    pper_d  = pper_q;
    pon_d   = pon_q;
    ppol_d  = ppol_q;
    pend_d  = pend_q;
    ack_d   = 1'b0;
    if (apply) begin
      if (bus.load_i) begin
        mode_d = bus.mode_i;
        per_d  = bus.periodCnt_i;
        on_d   = bus.onCnt_i;
        pol_d  = bus.polarity_i;
        ack_d  = 1'b1;
      end else if (pend_q) begin
        mode_d = pmode_q;
        per_d  = pper_q;
        on_d   = pon_q;
        pol_d  = ppol_q;
        ack_d  = 1'b1;
      end
      pend_d = 1'b0;
    end else if (bus.load_i) begin
      pmode_d = bus.mode_i;
      pper_d  = bus.periodCnt_i;
      pon_d   = bus.onCnt_i;
      ppol_d  = bus.polarity_i;
      pend_d  = 1'b1;
    end
  end

  // Compare and polarity: outputs reflect the current count with the active values.
  // run_q (not en_i) gates this so the last counted value still reaches the pin
  // one cycle after en_i drops, then the inactive level follows.
  always_comb begin
    raw   = '0;
    pwm_d = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      raw[k]   = (count_q < on_q[k*PWM_BW +: PWM_BW]);
      pwm_d[k] = run_q ? (raw[k] ^ pol_q[k]) : pol_q[k];
    end
    cstart_d = run_d && (count_d == CNT_ZERO);
  end

  // Counter, direction and run flag registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= CNT_ZERO;
      dir_q   <= DIR_UP;
      run_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
      run_q   <= run_d;
    end
  end

  // Active and pending setting registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q  <= 1'b0;
      per_q   <= '0;
      on_q    <= '0;
      pol_q   <= '0;
      pmode_q <= 1'b0;
      pper_q  <= '0;
      pon_q   <= '0;
      ppol_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      per_q   <= per_d;
      on_q    <= on_d;
      pol_q   <= pol_d;
      pmode_q <= pmode_d;
      pper_q  <= pper_d;
      pon_q   <= pon_d;
      ppol_q  <= ppol_d;
      pend_q  <= pend_d;
    end
  end

  // Output registers: PWM pins and the two status pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pwm_q    <= '0;
      ack_q    <= 1'b0;
      cstart_q <= 1'b0;
    end else begin
      pwm_q    <= pwm_d;
      ack_q    <= ack_d;
      cstart_q <= cstart_d;
    end
  end

  assign bus.count_o      = count_q;
  assign bus.pwm_o        = pwm_q;
  assign bus.loadAck_o    = ack_q;
  assign bus.cycleStart_o = cstart_q;

endmodule

// File: doc/pwm_multich.md
# pwm_multich

Multi-channel PWM generator, the parametrised successor to the single-channel PWM. A shared period counter drives CHANNELS compare channels. The block supports edge-aligned and center-aligned modes and per-channel output polarity. All settings are double-buffered: a shadow load takes effect only at a period boundary, so duty and period updates never produce runt pulses. It sits between the register/control logic and the output pads.

## Interface
- PWM_BW, 8, width of counter, period and compare values
- CHANNELS, 4, number of PWM outputs
- clk_i  in  1  system clock, all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- en_i  in  1  run enable; 0 = idle
- mode_i  in  1  0 = edge-aligned, 1 = center-aligned (shadowed)
- periodCnt_i  in  PWM_BW  period value P (shadowed)
- onCnt_i  in  CHANNELS*PWM_BW  compare value per channel; channel k at bits [k*PWM_BW +: PWM_BW] (shadowed)
- polarity_i  in  CHANNELS  1 = invert channel output (shadowed)
- load_i  in  1  single-cycle request to capture all shadowed inputs
- loadAck_o  out  1  one-cycle pulse when captured values become active
- cycleStart_o  out  1  one-cycle pulse at each period boundary
- count_o  out  PWM_BW  current counter value
- pwm_o  out  CHANNELS  PWM outputs

## Operation
- **Register sets.** The block holds three register sets:
  - Active registers: mode, P, on[k], pol[k].
  - Pending registers: one copy of each active register.
  - Flags: pend flag, run_q (registered en_i), dir (up/down).
- **Reset.** On reset, all of the following are 0: count_o, active and pending registers, pend, run_q, loadAck_o, cycleStart_o, pwm_o. dir = up.
- **Load capture.** load_i=1 captures all shadowed inputs into the pending registers and sets pend. A later load_i before the apply overwrites the pending values (last write wins).
- **Apply.** Pending values are copied to the active registers and pend is cleared:
  - on the clock edge where count_o becomes 0 at a period boundary while running, or
  - on any edge while en_i=0.
- **Load on an apply edge.** If load_i is high on an apply edge, the input values bypass straight into the active registers.
- **Edge mode.** Count sequence is 0,1,…,P,0,… (period P+1 cycles).
  - Channel raw state = (count_o < on[k]).
  - on=0 gives 0 %. on>P gives 100 %.
- **Center mode.** Count goes up 0→P, then down P-1→1, then returns to 0 (period 2P cycles). dir flips at P and at 0.
  - Raw state = (count_o < on[k]), evaluated in both directions.
  - High time is 2·on−1 cycles for 1≤on≤P, 2P cycles for on>P, and 0 cycles for on=0.
- **P=0.** In either mode count_o stays at 0. Raw state = (on[k]≠0).
- **Output.** pwm_o[k] = raw XOR pol[k], registered.
- **Idle (en_i=0).** On the next edge:
  - count_o ← 0 and dir ← up.
  - run_q ← 0.
  - pwm_o[k] ← pol[k] (inactive level).
- **Period boundary.** Boundary = run_q && count_o==0. cycleStart_o is high in every boundary cycle.
- **Width rules.** All compares are unsigned PWM_BW-bit. The counter never exceeds P, so no overflow is possible.

## Timing
- **Counter and run flag.**
  - count_o and run_q update on each edge.
  - The first edge sampling en_i=1 sets run_q.
  - count_o leaves 0 on the edge after that.
  - So the first cycleStart_o occurs one cycle after en_i rises.
- **Counter arithmetic.** Counter next-state and compares use the active registers. Values applied on a boundary edge govern the whole period that starts with count_o=0.
- **loadAck_o.** It is high in the same cycle as the first count_o=0 that uses the new values, so it coincides with cycleStart_o when running. When idle, it is high the cycle after the load edge.
- **Output latency.** pwm_o lags count_o by exactly 1 cycle: pwm_o in cycle t+1 reflects count_o and the active values in cycle t.
- **en_i falling mid-period.** The period is aborted. count_o=0 the next cycle and pwm_o goes to the inactive level one cycle after that. Pending values apply while idle.
- **rst_i mid-operation.** rst_i overrides load_i and en_i. All state takes reset values on the next edge.

## Test plan
- **Reset.** rst_i=1 for 2 cycles with arbitrary inputs → count_o=0, pwm_o=0, loadAck_o=0, cycleStart_o=0 on the edge after rst_i.
- **Edge mode.** PWM_BW=8, load P=9, on={0,3,10,255}, pol=0, edge mode; en_i=1 → period 10 cycles. Per-period high counts are ch0=0, ch1=3, ch2=10, ch3=10. cycleStart_o fires every 10 cycles.
- **Center mode.** load mode=1, P=4, on[1]=2 → count 0,1,2,3,4,3,2,1 repeating (8 cycles). ch1 is high 3 cycles, centered on count 0. Setting pol[1]=1 inverts it to 5 high cycles.
- **Shadow timing.** While running with P=9, on[0]=3, pulse load_i at count_o=5 with on[0]=7 → the current period keeps 3 high cycles. loadAck_o and cycleStart_o coincide at the next count_o=0, and the next period has 7 high cycles.
- **Double load and bypass.** Two loads at count_o=2 and count_o=6 → only the second value applies at the boundary. A load on the boundary edge itself is active immediately.
- **Enable and reset mid-period.** Drop en_i at count_o=4 → count_o=0 next cycle and pwm_o goes inactive the cycle after. Re-raise en_i → first cycleStart_o one cycle later. Assert rst_i mid-period → reset values next cycle.
